// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text link receive side: character width, the
// default end-of-message character, the sink FSM state encoding and a helper
// that counts set bits in a character (used for bit-error statistics).
// -----------------------------------------------------------------------------
package text_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] TERM_CHAR_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } sink_state_t;

    // Number of '1' bits in a character; the XOR of received and reference
    // characters fed through this gives the number of flipped bits.
    function automatic logic [3:0] popcount8(input logic [CHAR_W-1:0] value);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < CHAR_W; i++) begin
            total = total + {3'd0, value[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/sink_char_ram.sv
// -----------------------------------------------------------------------------
// sink_char_ram
// Simple dual-port character buffer: one synchronous write port and one
// registered read port, shaped so that it maps onto a single block RAM.
//
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   synchronous active-high, clears only the read register
//   wr_en     in   write strobe
//   wr_addr   in   write address
//   wr_data   in   character to store
//   rd_addr   in   read address
//   rd_data   out  contents at rd_addr, one cycle later
// -----------------------------------------------------------------------------
module sink_char_ram
    import text_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [DEPTH];

    // Storage array is never reset so it can live in block RAM.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read. A read of the address being written in the same cycle
    // sees the previous contents because the array update is non-blocking.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_sink_checker.sv
// -----------------------------------------------------------------------------
// text_sink_checker
// Final consumer of the text link. Captures decompressed characters into a
// readback buffer and compares each one with the time-aligned source
// character, accumulating character-error and bit-error statistics.
//
// Ports:
//   CLOCK_50        in   system clock
//   reset           in   synchronous active-high reset
//   start           in   arm a capture (honoured in IDLE and DONE)
//   data_in         in   received character
//   data_valid      in   data_in qualifier
//   ref_char        in   expected source character, aligned with data_in
//   rd_addr         in   buffer readback address
//   rd_data         out  buffer contents at rd_addr, registered
//   busy            out  capture in progress
//   done            out  capture finished, statistics final
//   char_count      out  characters stored in this capture
//   char_err_count  out  characters that differed from ref_char
//   bit_err_count   out  total differing bits
//   last_err        out  most recently stored character mismatched
// -----------------------------------------------------------------------------
module text_sink_checker
    import text_pkg::*;
#(
    parameter int                DEPTH     = 64,
    parameter int                AW        = 6,
    parameter logic [CHAR_W-1:0] TERM_CHAR = TERM_CHAR_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAR_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [CHAR_W-1:0] ref_char,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       char_count,
    output logic [AW:0]       char_err_count,
    output logic [AW+3:0]     bit_err_count,
    output logic              last_err
);

    sink_state_t state;
    sink_state_t state_next;

    logic [AW-1:0] wr_ptr;
    logic          is_term;
    logic          accept;
    logic          is_last_slot;
    logic          mismatch;
    logic [3:0]    bit_diff;

    assign is_term      = (data_in == TERM_CHAR);
    assign accept       = (state == ST_CAPTURE) && data_valid && !is_term;
    assign is_last_slot = (char_count == (AW+1)'(DEPTH - 1));
    assign mismatch     = (data_in != ref_char);
    assign bit_diff     = popcount8(data_in ^ ref_char);

    assign busy = (state == ST_CAPTURE);
    assign done = (state == ST_DONE);

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A capture ends either on the terminator or on the
    // write that fills the last buffer slot, so the pointer never wraps.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (data_valid && is_term) begin
                    state_next = ST_DONE;
                end else if (accept && is_last_slot) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_CAPTURE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Statistics and write pointer. Cleared on the arming edge so the new
    // capture starts from zero; frozen outside CAPTURE.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr         <= '0;
            char_count     <= '0;
            char_err_count <= '0;
            bit_err_count  <= '0;
            last_err       <= 1'b0;
        end else if ((state != ST_CAPTURE) && start) begin
            wr_ptr         <= '0;
            char_count     <= '0;
            char_err_count <= '0;
            bit_err_count  <= '0;
            last_err       <= 1'b0;
        end else if (accept) begin
            wr_ptr        <= wr_ptr + 1'b1;
            char_count    <= char_count + 1'b1;
            bit_err_count <= bit_err_count + (AW+4)'(bit_diff);
            last_err      <= mismatch;
            if (mismatch) begin
                char_err_count <= char_err_count + 1'b1;
            end
        end
    end

    sink_char_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .wr_en    (accept),
        .wr_addr  (wr_ptr),
        .wr_data  (data_in),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

endmodule

// File: tb/tb_text_sink_checker.sv
// -----------------------------------------------------------------------------
// tb_text_sink_checker
// Directed bench for text_sink_checker. Each capture pushes its expected final
// statistics into a scoreboard queue; a monitor pops and compares them when
// done rises. Reset, latency and readback values are compared directly.
// -----------------------------------------------------------------------------
module tb_text_sink_checker;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        int count;
        int char_errs;
        int bit_errs;
        int last;
    } expect_t;

    logic          CLOCK_50;
    logic          reset;
    logic          start;
    logic [7:0]    data_in;
    logic          data_valid;
    logic [7:0]    ref_char;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   char_count;
    logic [AW:0]   char_err_count;
    logic [AW+3:0] bit_err_count;
    logic          last_err;

    int      checks;
    int      fails;
    expect_t scoreboard[$];
    logic    done_prev;

    text_sink_checker #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .TERM_CHAR (8'h00)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .start          (start),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .ref_char       (ref_char),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .char_count     (char_count),
        .char_err_count (char_err_count),
        .bit_err_count  (bit_err_count),
        .last_err       (last_err)
    );

    // 50 MHz clock.
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Single comparison point; every check steps the counters used in the
    // summary line.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Scoreboard monitor: on each rising edge of done, the oldest expected
    // capture result is compared against the frozen statistics.
    always @(negedge CLOCK_50) begin
        if (reset) begin
            done_prev <= 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    expect_t e;
                    e = scoreboard.pop_front();
                    checkOutput("sb_char_count", int'(char_count), e.count);
                    checkOutput("sb_char_err_count", int'(char_err_count), e.char_errs);
                    checkOutput("sb_bit_err_count", int'(bit_err_count), e.bit_errs);
                    checkOutput("sb_last_err", int'(last_err), e.last);
                end
            end
            done_prev <= done;
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One valid character with its aligned reference.
    task automatic applyStimulus(input logic [7:0] ch, input logic [7:0] rf);
        data_in    = ch;
        ref_char   = rf;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic readBack(input int addr, input int expected, input string name);
        rd_addr = AW'(addr);
        tick();
        checkOutput(name, int'(rd_data), expected);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_char_count"}, int'(char_count), 0);
        checkOutput({tag, "_char_err_count"}, int'(char_err_count), 0);
        checkOutput({tag, "_bit_err_count"}, int'(bit_err_count), 0);
        checkOutput({tag, "_last_err"}, int'(last_err), 0);
        checkOutput({tag, "_rd_data"}, int'(rd_data), 0);
    endtask

    initial begin
        expect_t e;
        logic [7:0] ch;
        checks     = 0;
        fails      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        ref_char   = 8'h00;
        rd_addr    = '0;
        tick();
        tick();
        reset = 1'b0;
        checkCleared("reset");

        // Valids in IDLE are ignored.
        applyStimulus(8'h41, 8'h42);
        checkOutput("idle_ignore_count", int'(char_count), 0);
        checkOutput("idle_ignore_busy", int'(busy), 0);

        // Clean message "HELLO".
        $display("[TB] clean message");
        pulseStart();
        checkOutput("start_busy", int'(busy), 1);
        e = '{count: 5, char_errs: 0, bit_errs: 0, last: 0};
        scoreboard.push_back(e);
        applyStimulus(8'h48, 8'h48);
        checkOutput("latency_count", int'(char_count), 1);
        applyStimulus(8'h45, 8'h45);
        applyStimulus(8'h4C, 8'h4C);
        applyStimulus(8'h4C, 8'h4C);
        applyStimulus(8'h4F, 8'h4F);
        applyStimulus(8'h00, 8'h00);
        checkOutput("hello_done", int'(done), 1);
        checkOutput("hello_busy", int'(busy), 0);
        readBack(0, 8'h48, "hello_rd0");
        readBack(1, 8'h45, "hello_rd1");
        readBack(2, 8'h4C, "hello_rd2");
        readBack(3, 8'h4C, "hello_rd3");
        readBack(4, 8'h4F, "hello_rd4");

        // Restart from DONE, "ABC" against "ABD".
        $display("[TB] restart with errors");
        pulseStart();
        checkOutput("restart_count", int'(char_count), 0);
        checkOutput("restart_busy", int'(busy), 1);
        checkOutput("restart_done", int'(done), 0);
        e = '{count: 3, char_errs: 1, bit_errs: 3, last: 1};
        scoreboard.push_back(e);
        applyStimulus(8'h41, 8'h41);
        applyStimulus(8'h42, 8'h42);
        checkOutput("abc_last_err_before", int'(last_err), 0);
        applyStimulus(8'h43, 8'h44);
        checkOutput("abc_last_err_after", int'(last_err), 1);
        applyStimulus(8'h00, 8'h55);

        // Gapped valids with start pulses during CAPTURE.
        $display("[TB] gapped valids");
        pulseStart();
        e = '{count: 3, char_errs: 1, bit_errs: 1, last: 0};
        scoreboard.push_back(e);
        applyStimulus(8'h78, 8'h78);
        tick();
        tick();
        pulseStart();
        applyStimulus(8'h79, 8'h59);
        tick();
        pulseStart();
        checkOutput("gap_count_mid", int'(char_count), 2);
        checkOutput("gap_busy_mid", int'(busy), 1);
        applyStimulus(8'h7A, 8'h7A);
        applyStimulus(8'h00, 8'h00);
        // Valids in DONE do not change the frozen statistics.
        applyStimulus(8'h71, 8'h11);
        checkOutput("done_frozen_count", int'(char_count), 3);
        checkOutput("done_frozen_errs", int'(char_err_count), 1);
        checkOutput("done_still", int'(done), 1);

        // Fill the buffer without a terminator.
        $display("[TB] full buffer");
        pulseStart();
        e = '{count: 64, char_errs: 1, bit_errs: 4, last: 0};
        scoreboard.push_back(e);
        for (int i = 0; i < DEPTH; i++) begin
            ch = 8'h41 + 8'(i % 26);
            if (i == 10) begin
                applyStimulus(ch, ch ^ 8'h0F);
            end else begin
                applyStimulus(ch, ch);
            end
            if (i == DEPTH - 2) begin
                checkOutput("full_not_yet_done", int'(done), 0);
            end
        end
        checkOutput("full_done", int'(done), 1);
        applyStimulus(8'h7E, 8'h7E);
        checkOutput("full_65th_count", int'(char_count), 64);
        readBack(0, 8'h41, "full_rd0");
        readBack(63, 8'h4C, "full_rd63");

        // Reset in the middle of a capture.
        $display("[TB] reset mid-capture");
        pulseStart();
        applyStimulus(8'h31, 8'h30);
        applyStimulus(8'h32, 8'h32);
        checkOutput("mid_count_before_reset", int'(char_count), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkCleared("midreset");
        applyStimulus(8'h33, 8'h34);
        checkOutput("post_reset_ignore_count", int'(char_count), 0);
        checkOutput("post_reset_ignore_busy", int'(busy), 0);

        tick();
        tick();
        if (scoreboard.size() != 0) begin
            checkOutput("scoreboard_pending", scoreboard.size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
